// File: rtl/procyon_seg7_pkg.sv
// Shared constants and types for the procyon seven-segment scan driver.
// Segment patterns are active-low: bit 0 is the top segment, bit 6 the middle.
package procyon_seg7_pkg;

  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  // Index 0 sits in the rightmost slot of the literal.
  localparam logic [15:0][6:0] SEG7_PATTERNS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    IDLE,
    DEAD,
    DRIVE
  } scan_state_t;

endpackage

// File: rtl/procyon_seg7_decoder.sv
// Hex nibble to active-low seven-segment pattern; n_rst low forces a blank.
module procyon_seg7_decoder
  import procyon_seg7_pkg::*;
(
  input  logic       n_rst,
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG7_BLANK;
    if (n_rst) seg = SEG7_PATTERNS[nibble];
  end

endmodule

// File: rtl/procyon_seg7_mux.sv
// Time-multiplexed seven-segment driver with dead-time and frame-aligned updates.
// Optional leading-zero blanking is enabled with `define PROCYON_SEG7_LZ_BLANK_EN.
module procyon_seg7_mux
  import procyon_seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1024
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_en,
  input  logic                  i_load,
  input  logic [DIGITS*4-1:0]   i_value,
  output logic [6:0]            o_seg,
  output logic [DIGITS-1:0]     o_an,
  output logic                  o_frame
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{1'b1}};

  scan_state_t          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DIGITS*4-1:0]  pend_q, disp_q;
  logic                 pend_valid_q;
  logic                 boundary;
  logic [3:0]           nibble_sel;
  logic                 lz_blank;
  logic                 dec_en;
  logic [6:0]           dec_seg;
  logic [DIGITS-1:0]    an_d;
  logic                 frame_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Each slot is one DEAD cycle followed by SCAN_DIV-1 DRIVE cycles (cnt 1..SCAN_DIV-1).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (i_en) begin
          state_d = DEAD;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      DEAD: begin
        state_d = DRIVE;
        cnt_d   = CNT_W'(1);
      end
      DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DEAD;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
    if (!i_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end
  end

  // D only moves at a frame edge or when the scan restarts from IDLE.
  assign boundary = i_en && (o_frame || (state_q == IDLE));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend_q       <= '0;
      disp_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      if (i_load) pend_q <= i_value;
      if (boundary) begin
        pend_valid_q <= 1'b0;
        if (i_load)            disp_q <= i_value;
        else if (pend_valid_q) disp_q <= pend_q;
      end else if (i_load) begin
        pend_valid_q <= 1'b1;
      end
    end
  end

  always_comb begin
    nibble_sel = disp_q[int'(idx_d)*4 +: 4];
  end

`ifdef PROCYON_SEG7_LZ_BLANK_EN
  logic [IDX_W-1:0] lead_idx;

  // Digit 0 is always the floor, so an all-zero value still shows "0".
  always_comb begin
    lead_idx = '0;
    for (int d = 1; d < DIGITS; d++) begin
      if (disp_q[d*4 +: 4] != 4'h0) lead_idx = IDX_W'(d);
    end
    lz_blank = (idx_d > lead_idx);
  end
`else
  assign lz_blank = 1'b0;
`endif

  assign dec_en = (state_d == DRIVE) && !lz_blank;

  procyon_seg7_decoder u_decoder (
    .n_rst  (dec_en),
    .nibble (nibble_sel),
    .seg    (dec_seg)
  );

  always_comb begin
    an_d    = AN_OFF;
    frame_d = 1'b0;
    if (state_d == DRIVE) begin
      an_d    = ~(DIGITS'(1) << idx_d);
      frame_d = (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
    end
  end

  // Outputs follow the next state so segments and anodes always change together.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_seg   <= SEG7_BLANK;
      o_an    <= AN_OFF;
      o_frame <= 1'b0;
    end else begin
      o_seg   <= dec_seg;
      o_an    <= an_d;
      o_frame <= frame_d;
    end
  end

endmodule
